// File: rtl/and_not_gate_cell_pkg.sv
// rtl/and_not_gate_cell_pkg.sv - shared constants for the NAND-built AND/NOT gate cell
package and_not_gate_cell_pkg;

    // Position of each decoder output inside a lane's two-bit pair
    localparam int DEC_LO   = 0;
    localparam int DEC_HI   = 1;
    localparam int DEC_PAIR = 2;

endpackage

// File: rtl/and_not_gate_cell_if.sv
// rtl/and_not_gate_cell_if.sv - operand and result bundle for and_not_gate_cell
interface and_not_gate_cell_if
    import and_not_gate_cell_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic [WIDTH-1:0]          not_y;
    logic [WIDTH-1:0]          and_y;
    logic [DEC_PAIR*WIDTH-1:0] dec_y;
    logic [WIDTH-1:0]          not_q;
    logic [WIDTH-1:0]          and_q;
    logic [DEC_PAIR*WIDTH-1:0] dec_q;

    modport master (
        output a,
        output b,
        input  not_y,
        input  and_y,
        input  dec_y,
        input  not_q,
        input  and_q,
        input  dec_q
    );

    modport slave (
        input  a,
        input  b,
        output not_y,
        output and_y,
        output dec_y,
        output not_q,
        output and_q,
        output dec_q
    );

endinterface

// File: rtl/and_not_gate_cell_nand2_cell.sv
// rtl/and_not_gate_cell_nand2_cell.sv - 2-input NAND, the only primitive the gate cell is built from
module nand2_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// File: rtl/and_not_gate_cell.sv
// rtl/and_not_gate_cell.sv - per-lane NOT, AND and 2:1 decoder pair from NAND cells, with optional output register bank
module and_not_gate_cell
    import and_not_gate_cell_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    and_not_gate_cell_if.slave bus
);

    logic [WIDTH-1:0]          not_w;
    logic [WIDTH-1:0]          and_w;
    logic [DEC_PAIR*WIDTH-1:0] dec_w;

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        logic nand_ab;
        logic nand_lo;

        nand2_cell u_not (.a(bus.a[k]), .b(bus.a[k]), .y(not_w[k]));

        nand2_cell u_nand_ab (.a(bus.a[k]), .b(bus.b[k]), .y(nand_ab));
        nand2_cell u_and     (.a(nand_ab),  .b(nand_ab),  .y(and_w[k]));

        // Low decoder output is ~i & e: the lane's NOT output ANDed with the enable
        nand2_cell u_nand_lo (.a(not_w[k]), .b(bus.b[k]), .y(nand_lo));
        nand2_cell u_lo      (.a(nand_lo),  .b(nand_lo),  .y(dec_w[DEC_PAIR*k+DEC_LO]));

        assign dec_w[DEC_PAIR*k+DEC_HI] = and_w[k];
    end

    assign bus.not_y = not_w;
    assign bus.and_y = and_w;
    assign bus.dec_y = dec_w;

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0]          not_r;
        logic [WIDTH-1:0]          and_r;
        logic [DEC_PAIR*WIDTH-1:0] dec_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                not_r <= '0;
                and_r <= '0;
                dec_r <= '0;
            end else begin
                not_r <= not_w;
                and_r <= and_w;
                dec_r <= dec_w;
            end
        end

        assign bus.not_q = not_r;
        assign bus.and_q = and_r;
        assign bus.dec_q = dec_r;
    end else begin : g_noreg
        assign bus.not_q = '0;
        assign bus.and_q = '0;
        assign bus.dec_q = '0;
    end

endmodule

// File: tb/tb_and_not_gate_cell.sv
// tb/tb_and_not_gate_cell.sv - self-checking bench for and_not_gate_cell
module tb_and_not_gate_cell;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    and_not_gate_cell_if #(.WIDTH(1)) if1 ();
    and_not_gate_cell_if #(.WIDTH(4)) if4 ();
    and_not_gate_cell_if #(.WIDTH(2)) if2 ();

    and_not_gate_cell #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    and_not_gate_cell #(.WIDTH(4), .REG_OUT(1'b1)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    and_not_gate_cell #(.WIDTH(2), .REG_OUT(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    // Expected register contents, advanced once per posedge
    logic [0:0] e1_nq, e1_aq;
    logic [1:0] e1_dq;
    logic [3:0] e4_nq, e4_aq;
    logic [7:0] e4_dq;

    function automatic logic [3:0] not_ref(input logic [3:0] a, input int w);
        return (~a) & 4'((1 << w) - 1);
    endfunction

    function automatic logic [3:0] and_ref(input logic [3:0] a, input logic [3:0] b);
        return a & b;
    endfunction

    // Decoder pair per lane: 0 when disabled, 1 (low output) for select 0, 2 (high output) for select 1
    function automatic logic [7:0] dec_ref(input logic [3:0] a, input logic [3:0] b, input int w);
        int acc = 0;
        for (int k = 0; k < w; k++) begin
            int pair = b[k] ? (a[k] ? 2 : 1) : 0;
            acc += pair * (4 ** k);
        end
        return 8'(acc);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        chk({tag, ".not1"}, 64'(if1.not_y), 64'(not_ref(4'(if1.a), 1)));
        chk({tag, ".and1"}, 64'(if1.and_y), 64'(and_ref(4'(if1.a), 4'(if1.b))));
        chk({tag, ".dec1"}, 64'(if1.dec_y), 64'(dec_ref(4'(if1.a), 4'(if1.b), 1)));
        chk({tag, ".not4"}, 64'(if4.not_y), 64'(not_ref(if4.a, 4)));
        chk({tag, ".and4"}, 64'(if4.and_y), 64'(and_ref(if4.a, if4.b)));
        chk({tag, ".dec4"}, 64'(if4.dec_y), 64'(dec_ref(if4.a, if4.b, 4)));
        chk({tag, ".dec2"}, 64'(if2.dec_y), 64'(dec_ref(4'(if2.a), 4'(if2.b), 2)));
    endtask

    task automatic check_q(input string tag);
        chk({tag, ".not_q1"}, 64'(if1.not_q), 64'(e1_nq));
        chk({tag, ".and_q1"}, 64'(if1.and_q), 64'(e1_aq));
        chk({tag, ".dec_q1"}, 64'(if1.dec_q), 64'(e1_dq));
        chk({tag, ".not_q4"}, 64'(if4.not_q), 64'(e4_nq));
        chk({tag, ".and_q4"}, 64'(if4.and_q), 64'(e4_aq));
        chk({tag, ".dec_q4"}, 64'(if4.dec_q), 64'(e4_dq));
        chk({tag, ".q_off2"}, 64'({if2.not_q, if2.and_q, if2.dec_q}), 64'd0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) begin
            e1_nq = '0; e1_aq = '0; e1_dq = '0;
            e4_nq = '0; e4_aq = '0; e4_dq = '0;
        end else begin
            e1_nq = 1'(not_ref(4'(if1.a), 1));
            e1_aq = 1'(and_ref(4'(if1.a), 4'(if1.b)));
            e1_dq = 2'(dec_ref(4'(if1.a), 4'(if1.b), 1));
            e4_nq = not_ref(if4.a, 4);
            e4_aq = and_ref(if4.a, if4.b);
            e4_dq = dec_ref(if4.a, if4.b, 4);
        end
        #1;
        check_q(tag);
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b);
        if1.a = a[0];   if1.b = b[0];
        if4.a = a;      if4.b = b;
        if2.a = a[1:0]; if2.b = b[1:0];
        #1;
    endtask

    logic [3:0] tt_not [4];
    logic [3:0] tt_and [4];
    logic [1:0] tt_dec [4];
    logic [3:0] ra, rb;
    logic [1:0] pair;

    initial begin
        tt_not = '{4'd1, 4'd1, 4'd0, 4'd0};
        tt_and = '{4'd0, 4'd0, 4'd0, 4'd1};
        tt_dec = '{2'b00, 2'b01, 2'b00, 2'b10};

        // Reset state; combinational path ignores rst
        rst = 1'b1;
        drive(4'h0, 4'h0);
        tick("reset");
        check_comb("reset_comb");
        rst = 1'b0;

        // Truth table on the single-lane cell, index = {a,b}
        for (int i = 0; i < 4; i++) begin
            drive({3'b0, 1'(i >> 1)}, {3'b0, 1'(i & 1)});
            chk("tt.not_y", 64'(if1.not_y), 64'(tt_not[i]));
            chk("tt.and_y", 64'(if1.and_y), 64'(tt_and[i]));
            chk("tt.dec_y", 64'(if1.dec_y), 64'(tt_dec[i]));
            check_comb("tt");
            tick("tt");
        end

        // Latency: registered outputs change only at the following edge
        drive(4'h0, 4'h0);
        tick("lat0");
        drive(4'hF, 4'hF);
        chk("lat.and_q_early", 64'(if1.and_q), 64'd0);
        tick("lat1");
        chk("lat.and_q", 64'(if1.and_q), 64'd1);
        chk("lat.dec_q", 64'(if1.dec_q), 64'b10);
        chk("lat.not_q", 64'(if1.not_q), 64'd0);

        // One-cycle synchronous reset mid-stream
        rst = 1'b1;
        tick("srst");
        chk("srst.and_q", 64'(if1.and_q), 64'd0);
        chk("srst.dec_q", 64'(if1.dec_q), 64'd0);
        chk("srst.and_y", 64'(if1.and_y), 64'd1);
        rst = 1'b0;
        tick("srst_rel");
        chk("srst_rel.and_q", 64'(if1.and_q), 64'd1);
        chk("srst_rel.and_y", 64'(if1.and_y), 64'd1);

        // Reset pulse entirely between edges must not disturb the registers
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_q("async");
        chk("async.and_q", 64'(if1.and_q), 64'd1);

        // Multi-lane directed vector
        drive(4'b1010, 4'b0110);
        chk("ml.and_y", 64'(if4.and_y), 64'(4'b0010));
        chk("ml.not_y", 64'(if4.not_y), 64'(4'b0101));
        chk("ml.dec_y", 64'(if4.dec_y), 64'(8'b00_01_10_00));
        tick("ml");

        // Random traffic with one-hot decoder property
        for (int n = 0; n < 1000; n++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            drive(ra, rb);
            check_comb("rnd");
            for (int k = 0; k < 4; k++) begin
                pair = if4.dec_y[2*k +: 2];
                chk("rnd.onehot", 64'(pair != 2'b11 && (rb[k] || pair == 2'b00)), 64'd1);
            end
            tick("rnd");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
